// File: rtl/adc_pmod_captura_pkg.sv
// Shared constants and FSM state encoding for the Pmod ADC capture front end.
package adc_pmod_captura_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADC_BITS   = 12;
    localparam int LEAD_ZEROS = 4;
    localparam int ADC_OFFSET = 2048;
    localparam int BITCNT_W   = 5;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        TRAMA  = 2'd1,
        CARGA  = 2'd2,
        ESPERA = 2'd3
    } estado_t;

endpackage

// File: rtl/adc_pmod_captura_if.sv
// ADC serial bus plus filter-side sample outputs. Error_Trama exists only when
// ADC_CEROS_CHECK_EN is defined.
interface adc_pmod_captura_if #(parameter int N = 25);

    logic                Dato_Serial;
    logic                CS;
    logic                SCLK;
    logic signed [N-1:0] Uk;
    logic                Bandera_ADC;
`ifdef ADC_CEROS_CHECK_EN
    logic                Error_Trama;

    modport master (input Dato_Serial, output CS, output SCLK, output Uk,
                    output Bandera_ADC, output Error_Trama);
    modport slave  (output Dato_Serial, input CS, input SCLK, input Uk,
                    input Bandera_ADC, input Error_Trama);
`else
    modport master (input Dato_Serial, output CS, output SCLK, output Uk,
                    output Bandera_ADC);
    modport slave  (output Dato_Serial, input CS, input SCLK, input Uk,
                    input Bandera_ADC);
`endif

endinterface

// File: rtl/adc_pmod_captura_tick_muestreo.sv
// Free-running sample-rate divider: one-cycle tick every SAMPLE_DIV clocks.
module tick_muestreo #(
    parameter int SAMPLE_DIV = 10000
) (
    input  logic Clk,
    input  logic Reset,
    output logic tick
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_pmod_captura.sv
// Paced 16-bit SPI-style capture from a 12-bit Pmod ADC, converted to signed Q(N-F).F.
// Optional leading-zero frame check: define ADC_CEROS_CHECK_EN.
module adc_pmod_captura
    import adc_pmod_captura_pkg::*;
#(
    parameter int N          = 25,
    parameter int F          = 16,
    parameter int SCLK_DIV   = 5,
    parameter int SAMPLE_DIV = 10000,
    parameter int QUIET      = 10
) (
    input  logic Clk,
    input  logic Reset,
    adc_pmod_captura_if.master bus
);

    localparam int DIV_W = 16;
    localparam int SHIFT = F - (ADC_BITS - 1);
    localparam logic [ADC_BITS:0] OFFSET_C = ADC_OFFSET[ADC_BITS:0];
    localparam logic [DIV_W-1:0] SCLK_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] QUIET_LAST = DIV_W'(QUIET - 1);
    localparam logic [BITCNT_W-1:0] BIT_LAST = BITCNT_W'(FRAME_BITS - 1);

    // Offset-binary code to signed fixed point; exact, so no rounding or saturation.
    function automatic logic signed [N-1:0] code_to_uk(input logic [ADC_BITS-1:0] code);
        logic signed [ADC_BITS:0] s;
        logic signed [N-1:0]      ext;
        s   = $signed({1'b0, code}) - $signed(OFFSET_C);
        ext = {{(N - ADC_BITS - 1){s[ADC_BITS]}}, s};
        return ext <<< SHIFT;
    endfunction

    logic tick;

    tick_muestreo #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .tick  (tick)
    );

    estado_t              state_q, state_d;
    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;
    logic                 rise_q, rise_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic signed [N-1:0]  uk_q, uk_d;
    logic                 band_q, band_d;
    logic [FRAME_BITS-1:0] frame_w;
`ifdef ADC_CEROS_CHECK_EN
    logic                 err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        rise_d   = 1'b0;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        uk_d     = uk_q;
        band_d   = 1'b0;
        frame_w  = {shift_q[FRAME_BITS-2:0], bus.Dato_Serial};
`ifdef ADC_CEROS_CHECK_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            REPOSO: begin
                cs_d     = 1'b1;
                sclk_d   = 1'b1;
                div_d    = '0;
                bitcnt_d = '0;
                if (tick) begin
                    state_d = TRAMA;
                    cs_d    = 1'b0;
                end
            end
            TRAMA: begin
                if (div_q == SCLK_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    rise_d = ~sclk_q;
                end else begin
                    div_d = div_q + 1'b1;
                end
                // rise_q marks the first cycle SCLK is high after a low phase
                if (rise_q) begin
                    shift_d  = frame_w;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = CARGA;
                        cs_d    = 1'b1;
                        sclk_d  = 1'b1;
                        div_d   = '0;
                        rise_d  = 1'b0;
`ifdef ADC_CEROS_CHECK_EN
                        if (frame_w[FRAME_BITS-1 -: LEAD_ZEROS] != '0) begin
                            err_d = 1'b1;
                        end else begin
                            uk_d   = code_to_uk(frame_w[ADC_BITS-1:0]);
                            band_d = 1'b1;
                        end
`else
                        uk_d   = code_to_uk(frame_w[ADC_BITS-1:0]);
                        band_d = 1'b1;
`endif
                    end
                end
            end
            CARGA: begin
                state_d = ESPERA;
                div_d   = '0;
            end
            ESPERA: begin
                if (div_q == QUIET_LAST) begin
                    state_d = REPOSO;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = REPOSO;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= REPOSO;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            rise_q   <= 1'b0;
            div_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            uk_q     <= '0;
            band_q   <= 1'b0;
`ifdef ADC_CEROS_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            rise_q   <= rise_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            uk_q     <= uk_d;
            band_q   <= band_d;
`ifdef ADC_CEROS_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.CS          = cs_q;
    assign bus.SCLK        = sclk_q;
    assign bus.Uk          = uk_q;
    assign bus.Bandera_ADC = band_q;
`ifdef ADC_CEROS_CHECK_EN
    assign bus.Error_Trama = err_q;
`endif

endmodule

// File: tb/tb_adc_pmod_captura.sv
// Bench for adc_pmod_captura: ADC serial model, fixed vectors, random codes, reset corner cases.
`timescale 1ns/1ps
module tb_adc_pmod_captura;

    localparam int N = 25, F = 16, SCLK_DIV = 5, SAMPLE_DIV = 400, QUIET = 10;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    adc_pmod_captura_if #(.N(N)) bus();

    adc_pmod_captura #(.N(N), .F(F), .SCLK_DIV(SCLK_DIV), .SAMPLE_DIV(SAMPLE_DIV), .QUIET(QUIET)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0]  word;
        logic [N-1:0] uk;
    } vec_t;

    int checks = 0, errors = 0;
    int cyc = 0, falls = 0, last_falls = 0, sclk_viol = 0, band_cnt = 0;
    int t_fall = 0, prev_band = 0;
    bit prev_valid = 1'b0;
    logic [15:0]  frame_word = 16'h0800;
    logic [N-1:0] last_uk = '0;
    vec_t tbl[5];

    always @(posedge Clk) cyc <= cyc + 1;

    // ADC model: presents the next frame bit (MSB first) on every SCLK fall while CS is low
    always @(negedge bus.SCLK or posedge bus.CS) begin
        if (bus.CS === 1'b1) begin
            last_falls = falls;
            falls = 0;
        end else begin
            if (falls < 16) bus.Dato_Serial = frame_word[15 - falls];
            falls++;
        end
    end

    always @(negedge Clk) begin
        if (bus.CS === 1'b1 && bus.SCLK !== 1'b1) sclk_viol++;
        if (bus.Bandera_ADC === 1'b1) band_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [N-1:0] ref_uk(input int code);
        int v;
        v = (code - 2048) * (1 << (F - 11));
        return v[N-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_fall();
        int k = 0;
        while (bus.CS !== 1'b0 && k < 500) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 500) chk("cs_fall_timeout", 32'(k), 32'd0);
        t_fall = cyc;
    endtask

    task automatic finish_frame(input logic [N-1:0] exp_uk, input bit exp_band, input string tag);
        int k = 0;
        while (bus.CS !== 1'b1 && k < 300) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 300) chk({tag, "_cs_rise_timeout"}, 32'(k), 32'd0);
        chk({tag, "_cs_low_cycles"}, 32'(cyc - t_fall), 32'd161);
        chk({tag, "_sclk_falls"}, 32'(last_falls), 32'd16);
        if (exp_band) begin
            chk({tag, "_bandera"}, 32'(bus.Bandera_ADC), 32'd1);
            chk({tag, "_uk"}, 32'($unsigned(bus.Uk)), 32'(exp_uk));
            if (prev_valid) chk({tag, "_spacing"}, 32'(cyc - prev_band), 32'(SAMPLE_DIV));
            prev_band  = cyc;
            prev_valid = 1'b1;
            last_uk    = exp_uk;
        end
`ifdef ADC_CEROS_CHECK_EN
        else begin
            chk({tag, "_bandera"}, 32'(bus.Bandera_ADC), 32'd0);
            chk({tag, "_error_trama"}, 32'(bus.Error_Trama), 32'd1);
            chk({tag, "_uk_held"}, 32'($unsigned(bus.Uk)), 32'(last_uk));
            prev_valid = 1'b0;
        end
`endif
        @(negedge Clk);
        chk({tag, "_bandera_one_cycle"}, 32'(bus.Bandera_ADC), 32'd0);
`ifdef ADC_CEROS_CHECK_EN
        chk({tag, "_error_one_cycle"}, 32'(bus.Error_Trama), 32'd0);
`endif
    endtask

    initial begin
        int k;
        int r;
        int b0;
        logic prev_s;
        logic [11:0] code;

        tbl[0] = '{16'h0FFF, 25'h000FFE0};
        tbl[1] = '{16'h0000, 25'h1FF0000};
        tbl[2] = '{16'h0801, 25'h0000020};
        tbl[3] = '{16'h07FF, 25'h1FFFFE0};
        tbl[4] = '{16'h0C00, 25'h0008000};

        // reset held
        repeat (5) @(negedge Clk);
        chk("rst_cs", 32'(bus.CS), 32'd1);
        chk("rst_sclk", 32'(bus.SCLK), 32'd1);
        chk("rst_uk", 32'($unsigned(bus.Uk)), 32'd0);
        chk("rst_bandera", 32'(bus.Bandera_ADC), 32'd0);

        // release: first CS fall one full sample period later
        Reset = 1'b0;
        k = 0;
        while (k < 1000) begin
            @(posedge Clk);
            #1;
            k++;
            if (bus.CS === 1'b0) break;
        end
        chk("first_cs_fall_cycles", 32'(k), 32'(SAMPLE_DIV));
        @(negedge Clk);
        t_fall = cyc;
        finish_frame(ref_uk(12'h800), 1'b1, "mid_scale");
        chk("latency_tick_to_bandera", 32'(prev_band - t_fall + 1), 32'd162);

        for (int i = 0; i < 5; i++) begin
            frame_word = tbl[i].word;
            wait_fall();
            finish_frame(tbl[i].uk, 1'b1, "table");
        end

        for (int i = 0; i < 8; i++) begin
            code = 12'($urandom_range(0, 4095));
            frame_word = {4'h0, code};
            wait_fall();
            finish_frame(ref_uk(int'(code)), 1'b1, "random");
        end

        // reset pulse right after the 8th SCLK rise
        frame_word = 16'h0ABC;
        wait_fall();
        r = 0;
        k = 0;
        prev_s = bus.SCLK;
        while (r < 8 && k < 200) begin
            @(posedge Clk);
            #1;
            if (prev_s === 1'b0 && bus.SCLK === 1'b1) r++;
            prev_s = bus.SCLK;
            k++;
        end
        chk("mid_reset_rises_seen", 32'(r), 32'd8);
        Reset = 1'b1;
        #1;
        chk("mid_reset_cs", 32'(bus.CS), 32'd1);
        chk("mid_reset_sclk", 32'(bus.SCLK), 32'd1);
        b0 = band_cnt;
        repeat (3) @(negedge Clk);
        chk("mid_reset_uk", 32'($unsigned(bus.Uk)), 32'd0);
        last_uk = '0;
        prev_valid = 1'b0;
        frame_word = 16'h0555;
        Reset = 1'b0;
        wait_fall();
        chk("mid_reset_no_bandera", 32'(band_cnt), 32'(b0));
        finish_frame(ref_uk(12'h555), 1'b1, "after_reset");

`ifdef ADC_CEROS_CHECK_EN
        frame_word = 16'h1800;
        wait_fall();
        finish_frame('0, 1'b0, "bad_lead");
        frame_word = 16'h0FFF;
        wait_fall();
        finish_frame(ref_uk(12'hFFF), 1'b1, "after_bad");
`else
        frame_word = 16'hA800;
        wait_fall();
        finish_frame(ref_uk(12'h800), 1'b1, "lead_ignored");
`endif

        chk("sclk_high_when_cs_high", 32'(sclk_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
